// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: widths, opcodes and fetch state shared by fetch, ROM and decode.
// Opcode field is the top OPC_W bits of every instruction word.
package fetch_unit_pkg;

  localparam int PC_W_DEF      = 12;
  localparam int INSTR_W_DEF   = 32;
  localparam int MEM_DEPTH_DEF = 512;
  localparam int OPC_W         = 5;

  localparam logic [OPC_W-1:0] OP_JMP = 5'd13;
  localparam logic [OPC_W-1:0] OP_IN  = 5'd20;
  localparam logic [OPC_W-1:0] OP_HLT = 5'd21;
  localparam logic [OPC_W-1:0] OP_NOP = 5'd23;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_IN,
    S_HALT,
    S_FAULT
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(
    input logic [INSTR_W_DEF-1:0] w
  );
    return w[INSTR_W_DEF-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC select and ROM bound compare.
// Ports: pc_i current PC, redirect_i/target_i jump request, advance_i
//   sequential step, pc_d_o next PC, seq_o pc_i+1, bound_o PC at or
//   about to cross MEM_DEPTH.
module fetch_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_d_o,
  output logic [PC_W-1:0] seq_o,
  output logic            bound_o
);

  localparam int DW = PC_W + 1;
  localparam logic [DW-1:0] DEPTH = DW'(MEM_DEPTH);

  logic [DW-1:0] pc_ext;
  logic [DW-1:0] seq_ext;

  // One extra bit so pc+1 at the top of the PC range cannot wrap
  // past the compare.
  assign pc_ext  = {1'b0, pc_i};
  assign seq_ext = pc_ext + DW'(1);
  assign seq_o   = seq_ext[PC_W-1:0];

  assign bound_o = (pc_ext >= DEPTH) ||
                   (seq_ext == DEPTH);

  always_comb begin
    pc_d_o = pc_i;
    unique case (1'b1)
      redirect_i: pc_d_o = target_i;
      advance_i:  pc_d_o = seq_o;
      default:    pc_d_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch/decode instruction register.
// Ports: clock/reset; pc_o/instr_i ROM; stall_i, redirect_i/target_i,
//   in_strobe_i control; ir_o/ir_valid_o/ir_pc_o/link_o to decode;
//   halted_o after HLT; fault_o sticky ROM overrun.
module fetch_unit #(
  parameter int PC_W      = fetch_unit_pkg::PC_W_DEF,
  parameter int INSTR_W   = fetch_unit_pkg::INSTR_W_DEF,
  parameter int MEM_DEPTH = fetch_unit_pkg::MEM_DEPTH_DEF,
  parameter logic [4:0] OP_IN  = fetch_unit_pkg::OP_IN,
  parameter logic [4:0] OP_HLT = fetch_unit_pkg::OP_HLT
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    pc_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    target_i,
  input  logic               in_strobe_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic               ir_valid_o,
  output logic [PC_W-1:0]    ir_pc_o,
  output logic [PC_W-1:0]    link_o,
  output logic               halted_o,
  output logic               fault_o
);

  import fetch_unit_pkg::*;

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    seq_pc;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    ir_pc_q;
  logic [PC_W-1:0]    link_q;
  logic               ir_valid_q;
  logic               halted_q;
  logic               fault_q;
  logic               pend_q;

  logic [OPC_W-1:0]   opcode;
  logic               is_hlt;
  logic               is_in;
  logic               bound;
  logic               redir;
  logic               advance;

  assign opcode = instr_i[INSTR_W-1 -: OPC_W];
  assign is_hlt = (opcode == OP_HLT);
  assign is_in  = (opcode == OP_IN);

  // A faulted fetch is dead until reset, so redirects are ignored there.
  assign redir = redirect_i && (state_q != S_FAULT);

  assign advance = (state_q == S_RUN) && !redir &&
                   !stall_i && !bound && !is_hlt;

  fetch_next_pc #(
    .PC_W      (PC_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_next_pc (
    .pc_i       (pc_q),
    .redirect_i (redir),
    .target_i   (target_i),
    .advance_i  (advance),
    .pc_d_o     (pc_d),
    .seq_o      (seq_pc),
    .bound_o    (bound)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      link_q     <= PC_W'(1);
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (redir) begin
        // Wrong-path HLT/IN effects are cancelled.
        state_q    <= S_RUN;
        ir_valid_q <= 1'b0;
        halted_q   <= 1'b0;
        pend_q     <= 1'b0;
      end else if (stall_i) begin
        // Everything holds, but an input strobe must not be lost.
        if (state_q == S_WAIT_IN && in_strobe_i)
          pend_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_RUN: begin
            if (bound) begin
              state_q    <= S_FAULT;
              fault_q    <= 1'b1;
              ir_valid_q <= 1'b0;
            end else begin
              ir_q       <= instr_i;
              ir_pc_q    <= pc_q;
              link_q     <= seq_pc;
              ir_valid_q <= 1'b1;
              if (is_hlt) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
              end else if (is_in) begin
                state_q  <= S_WAIT_IN;
              end
            end
          end
          S_WAIT_IN: begin
            ir_valid_q <= 1'b0;
            if (in_strobe_i || pend_q) begin
              state_q <= S_RUN;
              pend_q  <= 1'b0;
            end
          end
          S_HALT: begin
            ir_valid_q <= 1'b0;
          end
          S_FAULT: begin
            ir_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign ir_pc_o    = ir_pc_q;
  assign link_o     = link_q;
  assign halted_o   = halted_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a per-cycle reference model.
// Two instances: full 512-word ROM, and an 8-word ROM for the overrun case.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] target = '0;
  logic        strobe = 1'b0;
  logic        z1 = 1'b0;
  logic [11:0] z12 = '0;

  logic [11:0] pc1, irpc1, link1;
  logic [31:0] instr1, ir1;
  logic        v1, halted1, fault1;
  logic [11:0] pc2, irpc2, link2;
  logic [31:0] instr2, ir2;
  logic        v2, halted2, fault2;

  int checks = 0;
  int passes = 0;
  bit small_done = 0;

  function automatic logic [31:0] rom_word(int a);
    logic [4:0] op;
    op = OP_NOP;
    if (a == 159) op = OP_HLT;
    if (a == 115 || a == 120) op = OP_IN;
    if (a == 50) op = OP_JMP;
    return {op, 27'(a)};
  endfunction

  function automatic logic [31:0] nop_word(int a);
    return {OP_NOP, 27'(a)};
  endfunction

  assign instr1 = rom_word(int'(pc1));
  assign instr2 = nop_word(int'(pc2));

  fetch_unit #(.MEM_DEPTH(512)) dut (
    .clock(clk), .reset(rst), .pc_o(pc1), .instr_i(instr1),
    .stall_i(stall), .redirect_i(redirect), .target_i(target),
    .in_strobe_i(strobe), .ir_o(ir1), .ir_valid_o(v1),
    .ir_pc_o(irpc1), .link_o(link1), .halted_o(halted1),
    .fault_o(fault1)
  );

  fetch_unit #(.MEM_DEPTH(8)) dut8 (
    .clock(clk), .reset(rst2), .pc_o(pc2), .instr_i(instr2),
    .stall_i(z1), .redirect_i(z1), .target_i(z12),
    .in_strobe_i(z1), .ir_o(ir2), .ir_valid_o(v2),
    .ir_pc_o(irpc2), .link_o(link2), .halted_o(halted2),
    .fault_o(fault2)
  );

  // Reference model: architectural view of the fetch stage.
  typedef struct {
    int pc; logic [31:0] ir; bit v; int irpc; int link;
    bit halted; bit fault; bit wt; bit pend;
  } m_t;

  m_t m1, m2;

  function automatic m_t m_reset();
    m_t m;
    m.pc = 0; m.ir = '0; m.v = 0; m.irpc = 0; m.link = 1;
    m.halted = 0; m.fault = 0; m.wt = 0; m.pend = 0;
    return m;
  endfunction

  function automatic m_t step(m_t m, int depth, logic [31:0] w,
                              bit stl, bit rd, int tgt, bit stb);
    m_t n = m;
    if (m.fault) return n;
    if (rd) begin
      n.pc = tgt; n.v = 0; n.halted = 0; n.wt = 0; n.pend = 0;
      return n;
    end
    if (stl) begin
      if (m.wt && stb) n.pend = 1;
      return n;
    end
    if (m.halted) begin n.v = 0; return n; end
    if (m.wt) begin
      n.v = 0;
      if (stb || m.pend) begin n.wt = 0; n.pend = 0; end
      return n;
    end
    if (m.pc >= depth || m.pc + 1 == depth) begin
      n.fault = 1; n.v = 0;
      return n;
    end
    n.ir = w; n.irpc = m.pc; n.link = m.pc + 1; n.v = 1;
    if (w[31:27] == OP_HLT) n.halted = 1;
    else begin
      n.pc = m.pc + 1;
      if (w[31:27] == OP_IN) n.wt = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m1 = m_reset();
    else m1 = step(m1, 512, rom_word(m1.pc), stall, redirect,
                   int'(target), strobe);

  always @(posedge clk or posedge rst2)
    if (rst2) m2 = m_reset();
    else m2 = step(m2, 8, nop_word(m2.pc), 0, 0, 0, 0);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
               name, act, act, exp, exp, $time);
    else passes++;
  endtask

  task automatic cmp(string t, logic [11:0] pc, logic [31:0] ir,
                     logic v, logic [11:0] irpc, logic [11:0] link,
                     logic h, logic f, m_t m);
    chk({t, ".pc"}, 32'(pc), 32'(m.pc));
    chk({t, ".ir"}, ir, m.ir);
    chk({t, ".valid"}, 32'(v), 32'(m.v));
    chk({t, ".ir_pc"}, 32'(irpc), 32'(m.irpc));
    chk({t, ".link"}, 32'(link), 32'(m.link));
    chk({t, ".halted"}, 32'(h), 32'(m.halted));
    chk({t, ".fault"}, 32'(f), 32'(m.fault));
  endtask

  always @(negedge clk) begin
    cmp("m512", pc1, ir1, v1, irpc1, link1, halted1, fault1, m1);
    cmp("m8", pc2, ir2, v2, irpc2, link2, halted2, fault2, m2);
  end

  task automatic wait_pc(int p);
    for (int k = 0; k < 60 && int'(pc1) != p; k++) @(negedge clk);
    chk("reach_pc", 32'(pc1), 32'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Overrun on the 8-word ROM, then async reset mid-cycle.
  initial begin
    @(negedge rst2);
    repeat (8) @(negedge clk);
    chk("d8_pc7", 32'(pc2), 32'd7);
    chk("d8_nofault", 32'(fault2), 32'd0);
    @(negedge clk);
    chk("d8_fault", 32'(fault2), 32'd1);
    chk("d8_pc_hold", 32'(pc2), 32'd7);
    chk("d8_valid0", 32'(v2), 32'd0);
    chk("d8_link", 32'(link2), 32'd7);
    @(posedge clk);
    #3 rst2 = 1'b1;
    #1;
    chk("d8_rst_pc", 32'(pc2), 32'd0);
    chk("d8_rst_fault", 32'(fault2), 32'd0);
    chk("d8_rst_valid", 32'(v2), 32'd0);
    chk("d8_rst_link", 32'(link2), 32'd1);
    #2 rst2 = 1'b0;
    @(negedge clk);
    chk("d8_restart_pc", 32'(pc2), 32'd1);
    chk("d8_restart_irpc", 32'(irpc2), 32'd0);
    chk("d8_restart_v", 32'(v2), 32'd1);
    small_done = 1;
  end

  initial begin
    @(negedge clk);
    chk("rst_pc", 32'(pc1), 32'd0);
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_link", 32'(link1), 32'd1);
    chk("rst_irpc", 32'(irpc1), 32'd0);
    chk("rst_ir", ir1, 32'd0);
    chk("rst_halted", 32'(halted1), 32'd0);
    chk("rst_fault", 32'(fault1), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("run_pc", 32'(pc1), 32'(i));
      if (i > 0) begin
        chk("run_irpc", 32'(irpc1), 32'(i - 1));
        chk("run_valid", 32'(v1), 32'd1);
      end
    end

    stall = 1;
    repeat (2) @(negedge clk);
    chk("stall_pc", 32'(pc1), 32'd3);
    chk("stall_irpc", 32'(irpc1), 32'd2);
    stall = 0;

    wait_pc(10);
    redirect = 1; target = 12'd56; stall = 1;
    @(negedge clk);
    redirect = 0; stall = 0;
    chk("redir_pc", 32'(pc1), 32'd56);
    chk("redir_bubble", 32'(v1), 32'd0);
    @(negedge clk);
    chk("redir_irpc", 32'(irpc1), 32'd56);
    chk("redir_valid", 32'(v1), 32'd1);
    chk("redir_link", 32'(link1), 32'd57);

    redirect = 1; target = 12'd157;
    @(negedge clk);
    redirect = 0;
    wait_pc(159);
    @(negedge clk);
    chk("hlt_halted", 32'(halted1), 32'd1);
    chk("hlt_irpc", 32'(irpc1), 32'd159);
    chk("hlt_pc", 32'(pc1), 32'd159);
    chk("hlt_op", 32'(ir1[31:27]), 32'(OP_HLT));
    repeat (20) @(negedge clk);
    chk("hlt_pc20", 32'(pc1), 32'd159);
    chk("hlt_valid20", 32'(v1), 32'd0);
    redirect = 1; target = 12'd0;
    @(negedge clk);
    redirect = 0;
    chk("unhalt", 32'(halted1), 32'd0);
    chk("unhalt_pc", 32'(pc1), 32'd0);
    @(negedge clk);
    chk("unhalt_irpc", 32'(irpc1), 32'd0);
    chk("unhalt_valid", 32'(v1), 32'd1);

    redirect = 1; target = 12'd114;
    @(negedge clk);
    redirect = 0;
    wait_pc(116);
    chk("in_irpc", 32'(irpc1), 32'd115);
    chk("in_op", 32'(ir1[31:27]), 32'(OP_IN));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_wait_pc", 32'(pc1), 32'd116);
      chk("in_wait_v", 32'(v1), 32'd0);
    end
    stall = 1; strobe = 1;
    @(negedge clk);
    strobe = 0;
    repeat (2) @(negedge clk);
    chk("in_stall_pc", 32'(pc1), 32'd116);
    stall = 0;
    @(negedge clk);
    chk("in_rel_pc", 32'(pc1), 32'd116);
    chk("in_rel_v", 32'(v1), 32'd0);
    @(negedge clk);
    chk("in_res_irpc", 32'(irpc1), 32'd116);
    chk("in_res_pc", 32'(pc1), 32'd117);

    wait_pc(121);
    @(negedge clk);
    chk("in2_pc", 32'(pc1), 32'd121);
    strobe = 1;
    @(negedge clk);
    strobe = 0;
    chk("in2_rel_v", 32'(v1), 32'd0);
    @(negedge clk);
    chk("in2_irpc", 32'(irpc1), 32'd121);
    chk("in2_pc_next", 32'(pc1), 32'd122);

    redirect = 1; target = 12'd30;
    @(negedge clk);
    target = 12'd40;
    @(negedge clk);
    redirect = 0;
    chk("b2b_pc", 32'(pc1), 32'd40);
    chk("b2b_v", 32'(v1), 32'd0);
    @(negedge clk);
    chk("b2b_irpc", 32'(irpc1), 32'd40);
    chk("b2b_link", 32'(link1), 32'd41);
    chk("b2b_ir", ir1, 32'hB800_0028);

    redirect = 1; target = 12'd600;
    @(negedge clk);
    redirect = 0;
    chk("oob_pc", 32'(pc1), 32'd600);
    chk("oob_nofault", 32'(fault1), 32'd0);
    @(negedge clk);
    chk("oob_fault", 32'(fault1), 32'd1);
    chk("oob_v", 32'(v1), 32'd0);
    redirect = 1; target = 12'd5;
    @(negedge clk);
    redirect = 0;
    chk("fault_sticky", 32'(fault1), 32'd1);
    chk("fault_pc", 32'(pc1), 32'd600);

    for (int k = 0; k < 200 && !small_done; k++) @(negedge clk);
    chk("d8_done", 32'(small_done), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
